// File: rtl/reg_wb_pkg.sv
// Shared types and helpers for the register write-back unit.
// Write addresses are {gfflag, num}: the upper half of the space is the float file.
package reg_wb_pkg;
    localparam int NSRC      = 3;
    localparam int NUM_W     = 4;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 2;
    localparam bit ZERO_DROP = 1'b1;

    function automatic int calc_raddr_w(input int num_w);
        return num_w + 1;
    endfunction

    localparam int RADDR_W = calc_raddr_w(NUM_W);
    localparam int NREG    = 2 ** RADDR_W;

    typedef struct packed {
        logic [RADDR_W-1:0] addr;
        logic [DATA_W-1:0]  data;
    } wb_entry_t;

    function automatic logic [NREG-1:0] onehot_en(input logic [RADDR_W-1:0] addr);
        logic [NREG-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return one << addr;
    endfunction
endpackage

// File: rtl/reg_writeback_unit_fifo.sv
// Per-source request FIFO; a push while full and a pop while empty are ignored.
// Pointers wrap naturally because DEPTH is a power of two.
module wb_fifo
    import reg_wb_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t push_entry,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/reg_writeback_unit.sv
// Multi-source register write-back: per-source FIFOs, round-robin pick of one
// request per cycle, registered single write port with one-hot enables.
module reg_writeback_unit
    import reg_wb_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NSRC-1:0]              in_valid,
    output logic [NSRC-1:0]              in_ready,
    input  logic [NSRC-1:0]              in_gfflag,
    input  logic [NSRC-1:0][NUM_W-1:0]   in_num,
    input  logic [NSRC-1:0][DATA_W-1:0]  in_data,
    output logic                         wr_valid,
    output logic [RADDR_W-1:0]           wr_addr,
    output logic [DATA_W-1:0]            wr_data,
    output logic [NREG-1:0]              wr_enables,
    output logic                         busy
);
    localparam int SRC_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0]    fifo_full;
    logic [NSRC-1:0]    fifo_empty;
    logic [NSRC-1:0]    pop;
    wb_entry_t          heads [NSRC];
    wb_entry_t          popped;
    logic               grant_valid;
    logic [SRC_W-1:0]   grant_idx;
    int                 cand;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               wr_valid_q, wr_valid_d;
    logic [RADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [NREG-1:0]    wr_enables_q, wr_enables_d;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        wb_entry_t push_entry;
        assign push_entry = '{addr: {in_gfflag[i], in_num[i]}, data: in_data[i]};
        wb_fifo u_fifo (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .push       (in_valid[i]),
            .pop        (pop[i]),
            .push_entry (push_entry),
            .head       (heads[i]),
            .full       (fifo_full[i]),
            .empty      (fifo_empty[i])
        );
    end

    // First non-empty source at or after the pointer, wrapping.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 0; k < NSRC; k++) begin
            cand = (int'(rr_ptr_q) + k) % NSRC;
            if (!grant_valid && !fifo_empty[SRC_W'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = SRC_W'(cand);
            end
        end
    end

    always_comb begin
        pop          = '0;
        popped       = heads[grant_idx];
        rr_ptr_d     = rr_ptr_q;
        wr_valid_d   = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_enables_d = '0;
        if (flush) begin
            wr_addr_d = '0;
            wr_data_d = '0;
        end else if (grant_valid) begin
            pop[grant_idx] = 1'b1;
            rr_ptr_d = (grant_idx == SRC_W'(NSRC - 1)) ? '0 : grant_idx + SRC_W'(1);
            // Address 0 is the hardwired general zero register: consume silently.
            if (!(ZERO_DROP && popped.addr == '0)) begin
                wr_valid_d   = 1'b1;
                wr_addr_d    = popped.addr;
                wr_data_d    = popped.data;
                wr_enables_d = onehot_en(popped.addr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_enables_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_enables_q <= wr_enables_d;
        end
    end

    assign in_ready   = ~fifo_full;
    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_enables = wr_enables_q;
    assign busy       = (|(~fifo_empty)) || wr_valid_q;
endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit with hand-derived expectations.
module tb_reg_writeback_unit;
    import reg_wb_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        flush;
    logic [NSRC-1:0]             in_valid;
    logic [NSRC-1:0]             in_ready;
    logic [NSRC-1:0]             in_gfflag;
    logic [NSRC-1:0][NUM_W-1:0]  in_num;
    logic [NSRC-1:0][DATA_W-1:0] in_data;
    logic                        wr_valid;
    logic [RADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]           wr_data;
    logic [NREG-1:0]             wr_enables;
    logic                        busy;

    int checks = 0;
    int errors = 0;

    reg_writeback_unit dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_gfflag  (in_gfflag),
        .in_num     (in_num),
        .in_data    (in_data),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_enables (wr_enables),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid  = '0;
        in_gfflag = '0;
        in_num    = '0;
        in_data   = '0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        flush = 1'b0;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got %0b want 0", wr_valid); end
        checks++; if (wr_addr !== 5'h00) begin errors++; $display("FAIL reset_wr_addr got %h want 00", wr_addr); end
        checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
        checks++; if (wr_enables !== 32'h0) begin errors++; $display("FAIL reset_wr_enables got %h want 0", wr_enables); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (in_ready !== 3'b111) begin errors++; $display("FAIL reset_in_ready got %b want 111", in_ready); end
    endtask

    task automatic test_single_write();
        in_valid     = 3'b001;
        in_gfflag[0] = 1'b0;
        in_num[0]    = 4'h3;
        in_data[0]   = 32'hDEADBEEF;
        step();
        in_valid = '0;
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b want 0", wr_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0b want 1", busy); end
        step();
        checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", wr_valid); end
        checks++; if (wr_addr !== 5'h03) begin errors++; $display("FAIL single_addr got %h want 03", wr_addr); end
        checks++; if (wr_enables !== 32'h0000_0008) begin errors++; $display("FAIL single_en got %h want 00000008", wr_enables); end
        checks++; if (wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h want deadbeef", wr_data); end
        step();
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle got %0b want 0", wr_valid); end
        checks++; if (wr_enables !== 32'h0) begin errors++; $display("FAIL single_en_clear got %h want 0", wr_enables); end
        checks++; if (wr_addr !== 5'h03) begin errors++; $display("FAIL single_addr_hold got %h want 03", wr_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %0b want 0", busy); end
    endtask

    task automatic test_zero_drop();
        in_valid     = 3'b010;
        in_gfflag[1] = 1'b0;
        in_num[1]    = 4'h0;
        in_data[1]   = 32'h1111_1111;
        step();
        in_gfflag[1] = 1'b1;
        in_num[1]    = 4'h0;
        in_data[1]   = 32'h2222_2222;
        step();
        in_valid = '0;
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL zero_drop_valid got %0b want 0", wr_valid); end
        checks++; if (wr_enables !== 32'h0) begin errors++; $display("FAIL zero_drop_en got %h want 0", wr_enables); end
        checks++; if (wr_addr !== 5'h03) begin errors++; $display("FAIL zero_drop_addr_hold got %h want 03", wr_addr); end
        checks++; if (wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL zero_drop_data_hold got %h want deadbeef", wr_data); end
        step();
        checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL float0_valid got %0b want 1", wr_valid); end
        checks++; if (wr_addr !== 5'h10) begin errors++; $display("FAIL float0_addr got %h want 10", wr_addr); end
        checks++; if (wr_enables !== 32'h0001_0000) begin errors++; $display("FAIL float0_en got %h want 00010000", wr_enables); end
        checks++; if (wr_data !== 32'h2222_2222) begin errors++; $display("FAIL float0_data got %h want 22222222", wr_data); end
        step();
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL zero_tail_valid got %0b want 0", wr_valid); end
    endtask

    // Pointer is 2 here, so source 2 wins the first pop and source 1 fills up.
    task automatic test_backpressure();
        in_valid     = 3'b110;
        in_gfflag    = '0;
        in_num[2]    = 4'h2;
        in_data[2]   = 32'hC000_0000;
        in_num[1]    = 4'h1;
        in_data[1]   = 32'hB000_0000;
        step();
        checks++; if (in_ready !== 3'b111) begin errors++; $display("FAIL bp_ready1 got %b want 111", in_ready); end
        in_valid   = 3'b010;
        in_data[1] = 32'hB000_0001;
        step();
        checks++; if (in_ready !== 3'b101) begin errors++; $display("FAIL bp_full got %b want 101", in_ready); end
        checks++; if (wr_data !== 32'hC000_0000) begin errors++; $display("FAIL bp_first_data got %h want c0000000", wr_data); end
        checks++; if (wr_addr !== 5'h02) begin errors++; $display("FAIL bp_first_addr got %h want 02", wr_addr); end
        in_data[1] = 32'hB000_0002;
        step();
        checks++; if (wr_data !== 32'hB000_0000) begin errors++; $display("FAIL bp_b0 got %h want b0000000", wr_data); end
        checks++; if (in_ready[1] !== 1'b1) begin errors++; $display("FAIL bp_ready_again got %0b want 1", in_ready[1]); end
        step();
        in_valid = '0;
        checks++; if (wr_data !== 32'hB000_0001) begin errors++; $display("FAIL bp_b1 got %h want b0000001", wr_data); end
        step();
        checks++; if (wr_valid !== 1'b1 || wr_data !== 32'hB000_0002) begin errors++; $display("FAIL bp_b2 got v=%0b %h want v=1 b0000002", wr_valid, wr_data); end
        step();
        checks++; if (wr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_drain got v=%0b busy=%0b want 0 0", wr_valid, busy); end
    endtask

    // Pointer starts at 2, so output order is source 2,0,1,2,0,1,...
    task automatic test_back_to_back();
        int              sent [NSRC];
        logic [NSRC-1:0] acc;
        bit              saw_stall;
        int              m;
        int              src;
        int              idx;
        logic [DATA_W-1:0]  exp_data;
        logic [RADDR_W-1:0] exp_addr;
        saw_stall = 1'b0;
        for (int i = 0; i < NSRC; i++) sent[i] = 0;
        for (int c = 0; c < 14; c++) begin
            for (int i = 0; i < NSRC; i++) begin
                in_valid[i]  = (sent[i] < 4);
                in_gfflag[i] = 1'b0;
                in_num[i]    = NUM_W'(1 + 4 * i + sent[i]);
                in_data[i]   = {16'(i), 16'(sent[i])};
            end
            acc = in_valid & in_ready;
            if (in_valid != '0 && in_ready != 3'b111) saw_stall = 1'b1;
            step();
            for (int i = 0; i < NSRC; i++) if (acc[i]) sent[i]++;
            if (c >= 1 && c <= 12) begin
                m        = c - 1;
                src      = (2 + m) % 3;
                idx      = m / 3;
                exp_data = {16'(src), 16'(idx)};
                exp_addr = {1'b0, NUM_W'(1 + 4 * src + idx)};
                checks++; if (wr_valid !== 1'b1 || wr_data !== exp_data || wr_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL b2b_out%0d got v=%0b a=%h d=%h want v=1 a=%h d=%h", m, wr_valid, wr_addr, wr_data, exp_addr, exp_data);
                end
            end
        end
        in_valid = '0;
        checks++; if (wr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_drain got v=%0b busy=%0b want 0 0", wr_valid, busy); end
        checks++; if (saw_stall !== 1'b1) begin errors++; $display("FAIL b2b_ready_toggle got %0b want 1", saw_stall); end
        checks++; if (sent[0] != 4 || sent[1] != 4 || sent[2] != 4) begin errors++; $display("FAIL b2b_accepts got %0d %0d %0d want 4 4 4", sent[0], sent[1], sent[2]); end
    endtask

    task automatic test_flush();
        in_valid  = 3'b111;
        in_gfflag = '0;
        for (int i = 0; i < NSRC; i++) begin
            in_num[i]  = NUM_W'(5 + i);
            in_data[i] = 32'hF000_0000 | 32'(i);
        end
        step();
        for (int i = 0; i < NSRC; i++) in_data[i] = 32'hF100_0000 | 32'(i);
        step();
        checks++; if (wr_valid !== 1'b1 || wr_data !== 32'hF000_0002) begin errors++; $display("FAIL flush_pre got v=%0b d=%h want v=1 f0000002", wr_valid, wr_data); end
        flush      = 1'b1;
        in_valid   = 3'b100;
        in_data[2] = 32'hBAD0_0000;
        step();
        flush    = 1'b0;
        in_valid = '0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %0b want 0", busy); end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", wr_valid); end
        checks++; if (wr_enables !== 32'h0) begin errors++; $display("FAIL flush_en got %h want 0", wr_enables); end
        checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL flush_data got %h want 0", wr_data); end
        checks++; if (in_ready !== 3'b111) begin errors++; $display("FAIL flush_ready got %b want 111", in_ready); end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if (wr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_quiet%0d got v=%0b busy=%0b d=%h want 0 0", c, wr_valid, busy, wr_data); end
        end
    endtask

    // Pointer sits at 2 before the reset; after it, source 1 must beat source 2.
    task automatic test_reset_mid();
        in_valid  = 3'b111;
        in_gfflag = '0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NSRC; i++) begin
                in_num[i]  = NUM_W'(8 + i);
                in_data[i] = 32'hA000_0000 | 32'(16 * i + c);
            end
            step();
        end
        in_valid = '0;
        checks++; if (wr_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre got v=%0b busy=%0b want 1 1", wr_valid, busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (wr_valid !== 1'b0 || wr_enables !== 32'h0) begin errors++; $display("FAIL rstmid_valid got v=%0b en=%h want 0 0", wr_valid, wr_enables); end
        checks++; if (wr_addr !== 5'h00 || wr_data !== 32'h0) begin errors++; $display("FAIL rstmid_out got a=%h d=%h want 00 0", wr_addr, wr_data); end
        checks++; if (busy !== 1'b0 || in_ready !== 3'b111) begin errors++; $display("FAIL rstmid_state got busy=%0b rdy=%b want 0 111", busy, in_ready); end
        in_valid   = 3'b110;
        in_num[1]  = 4'h6;
        in_data[1] = 32'h1111_0001;
        in_num[2]  = 4'h5;
        in_data[2] = 32'h2222_0002;
        step();
        in_valid = '0;
        step();
        checks++; if (wr_data !== 32'h1111_0001 || wr_addr !== 5'h06) begin errors++; $display("FAIL rstmid_rr_first got a=%h d=%h want 06 11110001", wr_addr, wr_data); end
        step();
        checks++; if (wr_data !== 32'h2222_0002 || wr_addr !== 5'h05) begin errors++; $display("FAIL rstmid_rr_second got a=%h d=%h want 05 22220002", wr_addr, wr_data); end
        step();
        checks++; if (wr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_drain got v=%0b busy=%0b want 0 0", wr_valid, busy); end
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        clear_inputs();
        test_reset();
        test_single_write();
        test_zero_drop();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_writeback_unit.md
Name: reg_writeback_unit

Overview:
Multi-source register write-back unit for the unified general/float register file. It accepts write requests from NSRC execution sources (e.g. ALU, FPU, load unit), each over a valid/ready interface. Each source has its own small FIFO. A round-robin arbiter selects one request per cycle and drives a registered single write port: a one-hot per-register enable vector, register number and data. It generalises the combinational write decoder with buffering, arbitration, zero-register suppression and flush.

Parameters:
NSRC, 3, number of write-back sources
NUM_W, 4, register index width within one file; full address is {gfflag, num}, RADDR_W = NUM_W+1
DATA_W, 32, data width
DEPTH, 2, per-source FIFO depth; power of two, >= 2
ZERO_DROP, 1, 1 = writes to address 0 (general r0) are consumed and discarded

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  synchronous clear of all FIFOs and the output stage (pipeline squash)
in_valid  in  NSRC  per-source request valid
in_ready  out  NSRC  per-source ready (= FIFO not full)
in_gfflag  in  NSRC  per-source 0: general, 1: float
in_num  in  NSRC x NUM_W  per-source register index
in_data  in  NSRC x DATA_W  per-source write data
wr_valid  out  1  registered write strobe
wr_addr  out  RADDR_W  registered {gfflag, num}
wr_data  out  DATA_W  registered write data
wr_enables  out  2**RADDR_W  registered one-hot enable: bit wr_addr set iff wr_valid
busy  out  1  any FIFO non-empty or wr_valid high

Behaviour:
- Reset (rst=1 at a clk edge): all FIFOs empty; wr_valid=0, wr_addr=0, wr_data=0, wr_enables=0; RR pointer=0; in_ready all 1 from the next cycle. Reset mid-operation discards all queued entries.
- flush: same effect as reset on FIFOs and outputs. The RR pointer is kept. Pushes in a flush cycle are discarded. rst has priority.
- Push: source i accepts on the edge where in_valid[i] && in_ready[i]. in_ready[i] = !full[i], purely from registered count; it does not depend on same-cycle pop. Order within a source is preserved.
- Simultaneous push and pop on the same FIFO: count unchanged, both take effect.
- Arbitration: each cycle, grant the first non-empty FIFO searching from RR pointer upward, wrapping modulo NSRC. Pop it. Pointer becomes (grant+1) mod NSRC. No grant means the pointer is unchanged. At most one pop per cycle.
- Output stage is registered. Popped entry appears on wr_* the cycle after the pop. With no pop, wr_valid=0 and wr_enables=0; wr_addr/wr_data hold.
- Latency, uncontended: accept edge t, pop edge t+1, wr_valid high in cycle after edge t+2... precisely: wr_valid is high during the cycle following edge t+1. That is 2 edges from accept to strobe visible.
- ZERO_DROP=1 and popped address == 0: entry consumed, wr_valid=0, wr_enables=0 that cycle. A float address 16 ({1,0000}) is NOT dropped.
- wr_enables = ({{(2**RADDR_W-1){0}},1} << wr_addr) when wr_valid, else 0.
- Same register written by two sources: each write is emitted separately in arbitration order; no merging or reordering beyond round-robin.
- Throughput: one write per cycle sustained. Each source gets at least 1 grant per NSRC cycles when backlogged.

Decomposition:
- Package reg_wb_pkg holds:
  - RADDR_W derivation helper
  - typedef wb_entry_t (packed struct: logic [RADDR_W-1:0] addr; logic [DATA_W-1:0] data)
  - a function for the one-hot enable
- Sub-module wb_fifo (synchronous, DEPTH entries of wb_entry_t, push/pop/flush, full/empty) is instantiated NSRC times. Arbiter and output register stay in the top.

Test Plan:
- Reset, then source 0 writes {0,3}=0xDEADBEEF -> 2 edges later wr_valid=1, wr_addr=5'h03, wr_enables=32'h0000_0008, wr_data=0xDEADBEEF, for exactly one cycle.
- All 3 sources push every cycle continuously -> grants cycle 0,1,2,0,1,2…. wr_valid stays 1 every cycle once the pipeline fills. Per-source data order preserved. in_ready toggles and no entry is lost.
- Source 1 pushes 3 entries back-to-back with DEPTH=2 and no pop possible (first cycle) -> in_ready[1]=0 after 2 accepts. The third is accepted only once a pop frees space. All 3 reach wr_* in order.
- Writes to {0,0} and {1,0} -> first consumed with wr_valid=0 and wr_enables=0. Second gives wr_valid=1, wr_addr=5'h10, wr_enables=32'h0001_0000.
- Fill FIFOs, assert flush for one cycle -> next cycle busy=0, wr_valid=0, in_ready all 1. Queued data never appears.
- rst asserted while FIFOs hold 2 entries each and wr_valid=1 -> next cycle all outputs 0. A subsequent push from source 2 is granted first, because the RR pointer is 0 and sources 0 and 1 are empty.
